uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rr_pick.sv | 46 ++++
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit-side control logic.
//   arb_state_e  : arbiter FSM encoding (IDLE / START / WAIT / GAP)
//   DBIT_DEF     : default data bits per frame
//   OVERSAMPLE   : s_tick pulses per bit period
//   TICK_CNT_W   : width of the shared WAIT/GAP tick counter
//   rr_index()   : round-robin search helper, wraps (last + k) into 0..n-1
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } arb_state_e;

    localparam int DBIT_DEF   = 8;
    localparam int OVERSAMPLE = 16;
    localparam int TICK_CNT_W = 16;

    // Position k steps after 'last' in a ring of n entries.
    function automatic int rr_index(input int last, input int k, input int n);
        return (last + k) % n;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin picker. Searches req_valid starting at last+1 and
// wrapping from NREQ-1 back to 0; the entry at 'last' itself is checked last,
// so a lone requester can still win repeatedly.
// Ports:
//   req_valid  in   NREQ  pending-request vector
//   last       in   IW    index of the previous winner
//   winner     out  NREQ  one-hot winner (all zero when nothing is pending)
//   winner_idx out  IW    binary index of the winner (0 when nothing pending)
//   any        out  1     at least one request pending
// -----------------------------------------------------------------------------
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] winner,
    output logic [IW-1:0]   winner_idx,
    output logic            any
);

    logic [IW-1:0] idx;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        idx        = '0;
        // k runs 1..NREQ so the previous winner is the lowest priority.
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'(rr_index(int'(last), k, NREQ));
            if (!any && req_valid[idx]) begin
                any        = 1'b1;
                winner_idx = idx;
            end
        end
        if (any) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NREQ byte producers. One byte is taken
// from the round-robin winner, handed to the transmitter with a one-cycle
// tx_start, and the frame is then supervised until tx_done_tick or a
// tick-based watchdog expires. An inter-frame gap of GAP_TICKS s_ticks follows
// every frame before the next grant.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; winner gets req_ready this cycle
// START  | tx_start high for one cycle, tx_din = held byte
// WAIT   | counting s_ticks until tx_done_tick or watchdog expiry
// GAP    | counting s_ticks of enforced idle line
//
// Ports:
//   clk           in   1          sole clock
//   reset_n       in   1          asynchronous active-low reset
//   req_valid     in   NREQ       requester i has a byte pending
//   req_data      in   NREQ*DBIT  byte of requester i at [i*DBIT +: DBIT]
//   req_ready     out  NREQ       one-hot accept strobe (IDLE only)
//   s_tick        in   1          oversampling tick
//   tx_start      out  1          one-cycle start pulse to the transmitter
//   tx_din        out  DBIT       byte to transmit, valid with tx_start
//   tx_done_tick  in   1          transmitter frame-complete pulse
//   grant_id      out  IW         owner of the current frame
//   busy          out  1          high outside IDLE
//   sent_tick     out  1          frame completed normally
//   timeout_err   out  1          watchdog aborted the frame
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int DBIT          = DBIT_DEF,
    parameter int GAP_TICKS     = 16,
    parameter int TIMEOUT_TICKS = 256,
    parameter int IW            = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DBIT-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 s_tick,
    output logic                 tx_start,
    output logic [DBIT-1:0]      tx_din,
    input  logic                 tx_done_tick,
    output logic [IW-1:0]        grant_id,
    output logic                 busy,
    output logic                 sent_tick,
    output logic                 timeout_err
);

    localparam logic [TICK_CNT_W-1:0] TO_LAST  = TICK_CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [TICK_CNT_W-1:0] GAP_LAST =
        TICK_CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    // With no gap configured the frame end returns straight to IDLE.
    localparam arb_state_e POST_FRAME = (GAP_TICKS == 0) ? S_IDLE : S_GAP;

    arb_state_e            state_q, state_d;
    logic [TICK_CNT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]         last_q, last_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [DBIT-1:0]       hold_q, hold_d;
    logic                  sent_q, sent_d;
    logic                  tout_q, tout_d;

    logic [NREQ-1:0]       pick_onehot;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;

    uart_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_valid  (req_valid),
        .last       (last_q),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            grant_q <= '0;
            hold_q  <= '0;
            sent_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            sent_q  <= sent_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        sent_d    = 1'b0;
        tout_d    = 1'b0;
        req_ready = '0;

        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    req_ready = pick_onehot;
                    hold_d    = req_data[int'(pick_idx)*DBIT +: DBIT];
                    grant_d   = pick_idx;
                    last_d    = pick_idx;
                    state_d   = S_START;
                end
            end

            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // done has priority over a coincident watchdog expiry
                if (tx_done_tick) begin
                    sent_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = POST_FRAME;
                end else if (s_tick) begin
                    if (cnt_q == TO_LAST) begin
                        tout_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = POST_FRAME;
                    end else begin
                        cnt_d = cnt_q + TICK_CNT_W'(1);
                    end
                end
            end

            S_GAP: begin
                if (s_tick) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + TICK_CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Transmitter-facing outputs come from registers only.
    assign tx_start    = (state_q == S_START);
    assign tx_din      = (state_q == S_START) ? hold_q : '0;
    assign busy        = (state_q != S_IDLE);
    assign grant_id    = grant_q;
    assign sent_tick   = sent_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        s_tick;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        tx_done_tick;
    logic [1:0]  grant_id;
    logic        busy;
    logic        sent_tick;
    logic        timeout_err;

    int total;
    int bad;

    uart_tx_arbiter #(
        .NREQ          (4),
        .DBIT          (8),
        .GAP_TICKS     (16),
        .TIMEOUT_TICKS (256)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .s_tick       (s_tick),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .grant_id     (grant_id),
        .busy         (busy),
        .sent_tick    (sent_tick),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] ready;
        logic [1:0] grant;
        logic [7:0] din;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Offers req in IDLE, checks the accept cycle and the START cycle, leaves
    // the FSM in its first WAIT cycle.
    task automatic grant_frame(input logic [3:0] v, input logic [3:0] rdy,
                               input logic [1:0] gid, input logic [7:0] din);
        req_valid = v;
        #1;
        chk("idle_ready", {28'd0, req_ready}, {28'd0, rdy});
        chk("idle_busy", {31'd0, busy}, 32'd0);
        step();
        req_valid = 4'b0000;
        #1;
        chk("start_pulse", {31'd0, tx_start}, 32'd1);
        chk("start_din", {24'd0, tx_din}, {24'd0, din});
        chk("start_grant", {30'd0, grant_id}, {30'd0, gid});
        chk("start_ready0", {28'd0, req_ready}, 32'd0);
        step();
        chk("wait_nostart", {31'd0, tx_start}, 32'd0);
        chk("wait_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            s_tick = 1'b1;
            step();
        end
        s_tick = 1'b0;
    endtask

    // FSM is in its first GAP cycle on entry; runs 16 ticks back to IDLE.
    task automatic gap_phase();
        for (int i = 0; i < 16; i++) begin
            s_tick = 1'b1;
            if (i == 15) begin
                #1;
                chk("gap_busy_last", {31'd0, busy}, 32'd1);
                chk("gap_ready0", {28'd0, req_ready}, 32'd0);
            end
            step();
        end
        s_tick = 1'b0;
        chk("gap_exit_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic done_now();
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("sent_pulse", {31'd0, sent_tick}, 32'd1);
        chk("sent_no_tout", {31'd0, timeout_err}, 32'd0);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset_n      = 1'b0;
        req_valid    = 4'b0000;
        req_data     = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        s_tick       = 1'b0;
        tx_done_tick = 1'b0;

        vecs[0]  = '{4'b1111, 4'b0001, 2'd0, 8'hA0};
        vecs[1]  = '{4'b1111, 4'b0010, 2'd1, 8'hA1};
        vecs[2]  = '{4'b1111, 4'b0100, 2'd2, 8'hA2};
        vecs[3]  = '{4'b1111, 4'b1000, 2'd3, 8'hA3};
        vecs[4]  = '{4'b1111, 4'b0001, 2'd0, 8'hA0};
        vecs[5]  = '{4'b1111, 4'b0010, 2'd1, 8'hA1};
        vecs[6]  = '{4'b1111, 4'b0100, 2'd2, 8'hA2};
        vecs[7]  = '{4'b1111, 4'b1000, 2'd3, 8'hA3};
        vecs[8]  = '{4'b1010, 4'b0010, 2'd1, 8'hA1};
        vecs[9]  = '{4'b1001, 4'b1000, 2'd3, 8'hA3};
        vecs[10] = '{4'b1001, 4'b0001, 2'd0, 8'hA0};
        vecs[11] = '{4'b0100, 4'b0100, 2'd2, 8'hA2};
        vecs[12] = '{4'b0100, 4'b0100, 2'd2, 8'hA2};

        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_start", {31'd0, tx_start}, 32'd0);
        chk("rst_din", {24'd0, tx_din}, 32'd0);
        chk("rst_grant", {30'd0, grant_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sent", {31'd0, sent_tick}, 32'd0);
        chk("rst_tout", {31'd0, timeout_err}, 32'd0);
        reset_n = 1'b1;
        step();

        // arbitration table: fairness, wrap, lone requester
        for (int v = 0; v < 13; v++) begin
            grant_frame(vecs[v].valid, vecs[v].ready, vecs[v].grant, vecs[v].din);
            wait_ticks(3);
            done_now();
            chk("grant_stable", {30'd0, grant_id}, {30'd0, vecs[v].grant});
            gap_phase();
        end

        // single request, done 160 ticks into WAIT
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'h55};
        grant_frame(4'b0001, 4'b0001, 2'd0, 8'h55);
        wait_ticks(160);
        chk("single_still_wait", {31'd0, sent_tick}, 32'd0);
        done_now();
        step();
        chk("sent_one_cycle", {31'd0, sent_tick}, 32'd0);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        gap_phase();

        // watchdog timeout, with requester 0 waiting through the gap
        grant_frame(4'b0010, 4'b0010, 2'd1, 8'hA1);
        wait_ticks(255);
        chk("to_255_none", {31'd0, timeout_err}, 32'd0);
        chk("to_255_busy", {31'd0, busy}, 32'd1);
        s_tick = 1'b1;
        step();
        s_tick = 1'b0;
        chk("to_256_err", {31'd0, timeout_err}, 32'd1);
        chk("to_256_nosent", {31'd0, sent_tick}, 32'd0);
        req_valid = 4'b0001;
        step();
        chk("to_err_one_cycle", {31'd0, timeout_err}, 32'd0);
        gap_phase();

        // requester 0 gets the grant only now; done coincides with 256th tick
        grant_frame(4'b0001, 4'b0001, 2'd0, 8'h55);
        wait_ticks(255);
        s_tick       = 1'b1;
        tx_done_tick = 1'b1;
        step();
        s_tick       = 1'b0;
        tx_done_tick = 1'b0;
        chk("both_sent", {31'd0, sent_tick}, 32'd1);
        chk("both_no_tout", {31'd0, timeout_err}, 32'd0);
        step();
        gap_phase();

        // reset mid-frame
        grant_frame(4'b0100, 4'b0100, 2'd2, 8'hA2);
        wait_ticks(5);
        reset_n = 1'b0;
        #1;
        chk("mrst_start", {31'd0, tx_start}, 32'd0);
        chk("mrst_din", {24'd0, tx_din}, 32'd0);
        chk("mrst_grant", {30'd0, grant_id}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_ready", {28'd0, req_ready}, 32'd0);
        chk("mrst_sent", {31'd0, sent_tick}, 32'd0);
        chk("mrst_tout", {31'd0, timeout_err}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        grant_frame(4'b1111, 4'b0001, 2'd0, 8'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
